// File: rtl/iloop_errgen_pkg.sv
// Shared definitions for the integrating-loop error generator.
// Holds the FSM state encoding, the default maximum decimation exponent,
// and width/saturation helpers used by the error path.
package iloop_errgen_pkg;

  localparam int DEC_MAX_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_LOCK = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // The difference of two w-bit signed values needs one extra bit.
  function automatic int diff_width(input int w);
    return w + 1;
  endfunction

  // Signed saturation limits for a w-bit word.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/iloop_errgen_boxcar_dec.sv
// Boxcar decimator: sums 2^dec_log2 valid samples and emits their floor
// average one cycle after the final sample of each block.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   clr                synchronous discard of any partial block
//   adc_in, adc_valid  signed sample and its qualifier
//   dec_log2           block exponent, latched on the first sample of a block
//   avg, avg_valid     block average and its one-cycle pulse
module iloop_errgen_boxcar_dec
  import iloop_errgen_pkg::*;
#(
  parameter int wadc    = 16,
  parameter int DEC_MAX = DEC_MAX_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr,
  input  logic signed [wadc-1:0] adc_in,
  input  logic                   adc_valid,
  input  logic        [3:0]      dec_log2,
  output logic signed [wadc-1:0] avg,
  output logic                   avg_valid
);

  localparam int WACC = wadc + DEC_MAX;
  localparam int WCNT = DEC_MAX + 1;

  logic signed [WACC-1:0] acc_q, acc_d;
  logic        [WCNT-1:0] count_q, count_d;
  logic        [3:0]      shift_q, shift_d;
  logic signed [wadc-1:0] avg_q, avg_d;
  logic                   avg_valid_q, avg_valid_d;

  logic        [3:0]      dec_clamped;
  logic        [3:0]      shift_eff;
  logic signed [WACC-1:0] sum;
  logic signed [WACC-1:0] avg_full;
  logic                   last;

  always_comb begin
    dec_clamped = (dec_log2 > 4'(DEC_MAX)) ? 4'(DEC_MAX) : dec_log2;
    // A block's length is fixed by the exponent seen on its first sample.
    shift_eff   = (count_q == '0) ? dec_clamped : shift_q;
    sum         = acc_q + $signed({{DEC_MAX{adc_in[wadc-1]}}, adc_in});
    last        = ((count_q + WCNT'(1)) == (WCNT'(1) << shift_eff));
    avg_full    = sum >>> shift_eff;

    acc_d       = acc_q;
    count_d     = count_q;
    shift_d     = shift_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;

    if (clr) begin
      acc_d   = '0;
      count_d = '0;
    end else if (adc_valid) begin
      shift_d = shift_eff;
      if (last) begin
        acc_d       = '0;
        count_d     = '0;
        avg_d       = avg_full[wadc-1:0];
        avg_valid_d = 1'b1;
      end else begin
        acc_d   = sum;
        count_d = count_q + WCNT'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      count_q     <= '0;
      shift_q     <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  assign avg       = avg_q;
  assign avg_valid = avg_valid_q;

endmodule

// File: rtl/iloop_errgen.sv
// Error front end for an integrating loop. Decimates ADC samples, subtracts
// the average from a ramped setpoint, saturates the result and strobes it,
// while sequencing loop start-up through IDLE/RAMP/LOCK/HOLD.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   adc_in, adc_valid       signed measurement and qualifier
//   dec_log2                decimation exponent (block = 2^dec_log2 samples)
//   setpoint, ramp_step     target and max change per strobe (0 = jump)
//   enable, hold            run and freeze requests
//   errin, strobe_out       saturated error and its one-cycle qualifier
//   loop_reset, loop_static downstream integrator clear / open-loop select
//   at_setpoint             high while locked on the setpoint
module iloop_errgen
  import iloop_errgen_pkg::*;
#(
  parameter int wadc    = 16,
  parameter int win     = 16,
  parameter int DEC_MAX = DEC_MAX_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic signed [wadc-1:0] adc_in,
  input  logic                   adc_valid,
  input  logic        [3:0]      dec_log2,
  input  logic signed [wadc-1:0] setpoint,
  input  logic        [wadc-1:0] ramp_step,
  input  logic                   enable,
  input  logic                   hold,
  output logic signed [win-1:0]  errin,
  output logic                   strobe_out,
  output logic                   loop_reset,
  output logic                   loop_static,
  output logic                   at_setpoint
);

  localparam int WD = diff_width(wadc);
  localparam logic signed [WD-1:0] SAT_HI = WD'(sat_max(win));
  localparam logic signed [WD-1:0] SAT_LO = WD'(sat_min(win));

  state_e                 state_q, state_d;
  logic signed [wadc-1:0] sp_cur_q, sp_cur_d;
  logic signed [win-1:0]  errin_q, errin_d;
  logic                   strobe_q, strobe_d;

  logic signed [wadc-1:0] avg;
  logic                   avg_valid;
  logic                   dec_clr;
  logic                   emit;
  logic                   sp_eq;
  logic signed [WD-1:0]   sp_ext, avg_ext, set_ext, step_ext;
  logic signed [WD-1:0]   diff, sp_gap, sp_move;
  logic        [WD-1:0]   gap_mag;
  logic signed [wadc-1:0] sp_ramped;

  // Leaving a running state discards the partial block so a restart always
  // begins on a fresh block.
  assign dec_clr = !enable && (state_q != ST_IDLE);

  iloop_errgen_boxcar_dec #(
    .wadc    (wadc),
    .DEC_MAX (DEC_MAX)
  ) u_dec (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (dec_clr),
    .adc_in    (adc_in),
    .adc_valid (adc_valid),
    .dec_log2  (dec_log2),
    .avg       (avg),
    .avg_valid (avg_valid)
  );

  assign sp_eq = (sp_cur_q == setpoint);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; dropping enable wins over everything else.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = sp_eq ? ST_LOCK : ST_RAMP;
        ST_RAMP: begin
          if (hold)       state_d = ST_HOLD;
          else if (sp_eq) state_d = ST_LOCK;
        end
        ST_LOCK: begin
          if (hold)        state_d = ST_HOLD;
          else if (!sp_eq) state_d = ST_RAMP;
        end
        ST_HOLD: if (!hold) state_d = sp_eq ? ST_LOCK : ST_RAMP;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    loop_reset  = (state_q == ST_IDLE);
    loop_static = (state_q == ST_IDLE);
    at_setpoint = (state_q == ST_LOCK);
  end

  // Error, saturation and setpoint ramp
  always_comb begin
    sp_ext   = $signed({sp_cur_q[wadc-1], sp_cur_q});
    avg_ext  = $signed({avg[wadc-1], avg});
    set_ext  = $signed({setpoint[wadc-1], setpoint});
    step_ext = $signed({1'b0, ramp_step});
    diff     = sp_ext - avg_ext;
    sp_gap   = set_ext - sp_ext;
    gap_mag  = sp_gap[WD-1] ? (-sp_gap) : sp_gap;
    sp_move  = sp_gap[WD-1] ? (sp_ext - step_ext) : (sp_ext + step_ext);

    if ((ramp_step == '0) || (gap_mag <= {1'b0, ramp_step})) sp_ramped = setpoint;
    else                                                      sp_ramped = sp_move[wadc-1:0];

    // hold and enable are checked directly so a block finishing on the
    // cycle either changes is not strobed.
    emit = avg_valid && enable && !hold &&
           ((state_q == ST_RAMP) || (state_q == ST_LOCK));

    errin_d  = errin_q;
    sp_cur_d = sp_cur_q;
    strobe_d = emit;
    if (emit) begin
      if (diff > SAT_HI)      errin_d = SAT_HI[win-1:0];
      else if (diff < SAT_LO) errin_d = SAT_LO[win-1:0];
      else                    errin_d = diff[win-1:0];
      sp_cur_d = sp_ramped;
    end else if ((state_q == ST_IDLE) && avg_valid) begin
      // Track the measurement while idle so the loop starts bumplessly.
      sp_cur_d = avg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_cur_q <= '0;
      errin_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      sp_cur_q <= sp_cur_d;
      errin_q  <= errin_d;
      strobe_q <= strobe_d;
    end
  end

  assign errin      = errin_q;
  assign strobe_out = strobe_q;

endmodule
